q_serializer: RTL

//  Transmit end of the serialized charge link: converts a parallel charge value into a burst
//  of unit pulses on q_serialized, one pulse per Q_PER_PULSE of charge, followed by a quiet

---
 rtl/q_serializer_if.sv | 25 ++
 rtl/q_serializer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/q_serializer_if.sv
// Handshake and result bundle between the charge source and q_serializer.
// The master side requests conversions; the slave side is the serializer itself.
interface q_serializer_if #(
    parameter int WIDTH     = 10,
    parameter int WTD_WIDTH = 2
);
    logic                 start;
    logic [WIDTH-1:0]     q_in;
    logic                 q_serialized;
    logic                 busy;
    logic                 done;
    logic [WTD_WIDTH:0]   pulse_count;
    logic                 saturated;
    logic [WIDTH:0]       remainder;

    modport master (
        output start, q_in,
        input  q_serialized, busy, done, pulse_count, saturated, remainder
    );

    modport slave (
        input  start, q_in,
        output q_serialized, busy, done, pulse_count, saturated, remainder
    );
endinterface

// File: rtl/q_serializer.sv
// Charge-to-pulse-burst serializer: emits one unit pulse per Q_PER_PULSE of charge, then a guard gap.
// Optional feature: define Q_SERIALIZER_REMAINDER_CARRY_EN to carry the truncation error into the next run.
module q_serializer #(
    parameter int WIDTH       = 10,
    parameter int WTD_WIDTH   = 2,
    parameter int Q_PER_PULSE = 30,
    parameter int PULSE_HIGH  = 1,
    parameter int PULSE_LOW   = 1,
    parameter int GAP_CYCLES  = 2**WTD_WIDTH + 2
) (
    input  logic           clk,
    input  logic           rst,
    q_serializer_if.slave  bus
);

    localparam int MAX_PULSES = 2**(WTD_WIDTH+1) - 1;
    localparam int TMAX_HL    = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
    localparam int TMAX       = (GAP_CYCLES > TMAX_HL) ? GAP_CYCLES : TMAX_HL;
    localparam int TW         = $clog2(TMAX + 1);

    localparam logic [WIDTH:0]     Q_STEP    = (WIDTH+1)'(Q_PER_PULSE);
    localparam logic [WTD_WIDTH:0] MAX_CNT   = (WTD_WIDTH+1)'(MAX_PULSES);
    localparam logic [TW-1:0]      HIGH_LAST = TW'(PULSE_HIGH - 1);
    localparam logic [TW-1:0]      LOW_LAST  = TW'(PULSE_LOW - 1);
    localparam logic [TW-1:0]      GAP_LAST  = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        GAP,
        DONE
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [WIDTH:0]      residual;
    logic [WIDTH:0]      load_value;
    logic                q_serialized_r;
    logic                busy_r;
    logic                done_r;
    logic [WTD_WIDTH:0]  pulse_count_r;
    logic                saturated_r;
    logic [WIDTH:0]      remainder_r;
    logic                charge_left;
    logic                room_left;

`ifdef Q_SERIALIZER_REMAINDER_CARRY_EN
    logic [WIDTH:0]      carry;

    // Unsent charge from the previous run is folded into the next request, except after a
    // saturated run where the leftover is deliberately dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= '0;
        end else if (state == GAP && timer == GAP_LAST) begin
            carry <= saturated_r ? '0 : residual;
        end
    end

    assign load_value = {1'b0, bus.q_in} + carry;
`else
    assign load_value = {1'b0, bus.q_in};
`endif

    assign charge_left = (residual >= Q_STEP);
    assign room_left   = (pulse_count_r != MAX_CNT);

    // Single FSM: the first pulse is issued directly from IDLE so q_serialized rises the
    // cycle after start; each HIGH entry consumes one quantum of residual charge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            residual       <= '0;
            q_serialized_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pulse_count_r  <= '0;
            saturated_r    <= 1'b0;
            remainder_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    timer  <= '0;
                    if (bus.start) begin
                        busy_r      <= 1'b1;
                        saturated_r <= 1'b0;
                        if (load_value >= Q_STEP) begin
                            state          <= HIGH;
                            residual       <= load_value - Q_STEP;
                            pulse_count_r  <= (WTD_WIDTH+1)'(1);
                            q_serialized_r <= 1'b1;
                        end else begin
                            state          <= GAP;
                            residual       <= load_value;
                            pulse_count_r  <= '0;
                            q_serialized_r <= 1'b0;
                        end
                    end
                end

                HIGH: begin
                    if (timer == HIGH_LAST) begin
                        state          <= LOW;
                        timer          <= '0;
                        q_serialized_r <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                LOW: begin
                    if (timer == LOW_LAST) begin
                        timer <= '0;
                        if (charge_left && room_left) begin
                            state          <= HIGH;
                            residual       <= residual - Q_STEP;
                            pulse_count_r  <= pulse_count_r + 1'b1;
                            q_serialized_r <= 1'b1;
                        end else begin
                            state       <= GAP;
                            saturated_r <= charge_left;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                GAP: begin
                    // The gap must outlast the receiver watchdog so it flags the burst as complete.
                    if (timer == GAP_LAST) begin
                        state       <= DONE;
                        timer       <= '0;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        remainder_r <= residual;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end

                default: begin
                    state          <= IDLE;
                    timer          <= '0;
                    q_serialized_r <= 1'b0;
                    busy_r         <= 1'b0;
                    done_r         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q_serialized = q_serialized_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.pulse_count  = pulse_count_r;
    assign bus.saturated    = saturated_r;
    assign bus.remainder    = remainder_r;

endmodule
